// File: rtl/twp_master.sv
// twp_master: initiating end of the single-data-line two-wire link.
// Takes one register read or write per host handshake, serialises it onto
// SDA one bit per clk (LSB first), and for reads releases SDA, hunts the
// slave's 1->0 data marker and deserialises the 16-bit reply.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   host_req/ready    request handshake; accepted when both high at a clk edge
//   host_cmd          1 = write, 0 = read (sampled at acceptance)
//   host_addr         8-bit register address (sampled at acceptance)
//   host_wdata        16-bit write data (sampled at acceptance)
//   host_done         one-cycle completion pulse
//   host_rdata        read data, updated with a successful read's done pulse
//   host_err          with host_done: 1 = read marker timeout
//   SCL               frame indicator, low from start bit through the gap
//   SDA               serial data, driven when oe_q else released (pull-up)
//
// state | meaning
// IDLE  | SDA driven high, ready for a request
// START | start bit (0)
// OP    | command bit
// ADDR  | address bits 0..7
// WDATA | write data bits 0..15
// TURN  | line released, hunting the slave's 1->0 marker
// RDATA | shifting in read data bits 0..15
// REND  | slave stop bit, ignored
// GAP   | SDA driven high for GAP cycles before returning to IDLE
module twp_master #(
  parameter int GAP     = 2,
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_req,
  input  logic        host_cmd,
  input  logic [7:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ready,
  output logic        host_done,
  output logic [15:0] host_rdata,
  output logic        host_err,
  output logic        SCL,
  inout  wire         SDA
);

  typedef enum logic [3:0] {
    IDLE, START, OP, ADDR, WDATA, TURN, RDATA, REND, GAP_ST
  } state_t;

  localparam logic [3:0] TURN_LOAD = 4'(TIMEOUT - 1);
  localparam logic [3:0] GAP_LOAD  = 4'(GAP - 1);

  state_t      state_q, state_d;
  logic        sda_q, sda_d;
  logic        oe_q, oe_d;
  logic        cmd_q;
  logic [7:0]  addr_q;
  logic [15:0] wdata_q;
  logic [3:0]  bit_cnt_q;
  logic [3:0]  nxt_idx;
  logic [3:0]  tmr_q;
  logic        prev_one_q;
  logic        err_q;
  logic [15:0] rdata_sh_q;
  logic        sda_bit;

  // Released line reads high through the external pull-up.
  assign SDA        = oe_q ? sda_q : 1'bz;
  assign sda_bit    = SDA;
  assign host_ready = (state_q == IDLE);
  assign SCL        = (state_q == IDLE);
  assign nxt_idx    = bit_cnt_q + 4'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state plus the next registered SDA level / output enable, so the
  // pin changes exactly at the state boundary.
  always_comb begin
    state_d = state_q;
    sda_d   = 1'b1;
    oe_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (host_req) begin
          state_d = START;
          sda_d   = 1'b0;
        end
      end
      START: begin
        state_d = OP;
        sda_d   = cmd_q;
      end
      OP: begin
        state_d = ADDR;
        sda_d   = addr_q[0];
      end
      ADDR: begin
        if (bit_cnt_q[2:0] == 3'd7) begin
          if (cmd_q) begin
            state_d = WDATA;
            sda_d   = wdata_q[0];
          end else begin
            state_d = TURN;
            oe_d    = 1'b0;
          end
        end else begin
          sda_d = addr_q[nxt_idx[2:0]];
        end
      end
      WDATA: begin
        if (bit_cnt_q == 4'd15) state_d = GAP_ST;
        else                    sda_d   = wdata_q[nxt_idx];
      end
      TURN: begin
        oe_d = 1'b0;
        // A marker on the last allowed cycle still wins over the timeout.
        if (prev_one_q && !sda_bit) begin
          state_d = RDATA;
        end else if (tmr_q == 4'd0) begin
          state_d = GAP_ST;
          oe_d    = 1'b1;
        end
      end
      RDATA: begin
        oe_d = 1'b0;
        if (bit_cnt_q == 4'd15) state_d = REND;
      end
      REND: begin
        state_d = GAP_ST;
      end
      GAP_ST: begin
        if (tmr_q == 4'd0) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sda_q      <= 1'b1;
      oe_q       <= 1'b1;
      cmd_q      <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 16'h0000;
      bit_cnt_q  <= 4'd0;
      tmr_q      <= 4'd0;
      prev_one_q <= 1'b0;
      err_q      <= 1'b0;
      rdata_sh_q <= 16'h0000;
      host_done  <= 1'b0;
      host_err   <= 1'b0;
      host_rdata <= 16'h0000;
    end else begin
      sda_q     <= sda_d;
      oe_q      <= oe_d;
      host_done <= 1'b0;

      if (state_q == IDLE && host_req) begin
        cmd_q   <= host_cmd;
        addr_q  <= host_addr;
        wdata_q <= host_wdata;
      end

      if (state_d != state_q) bit_cnt_q <= 4'd0;
      else                    bit_cnt_q <= bit_cnt_q + 4'd1;

      // Shared down-counter: TURN timeout budget, then GAP length.
      if (state_d == TURN && state_q != TURN)
        tmr_q <= TURN_LOAD;
      else if (state_d == GAP_ST && state_q != GAP_ST)
        tmr_q <= GAP_LOAD;
      else if (tmr_q != 4'd0)
        tmr_q <= tmr_q - 4'd1;

      if (state_q != TURN) prev_one_q <= 1'b0;
      else                 prev_one_q <= sda_bit;

      if (state_d == GAP_ST && state_q != GAP_ST)
        err_q <= (state_q == TURN);

      if (state_q == RDATA)
        rdata_sh_q <= {sda_bit, rdata_sh_q[15:1]};

      if (state_q == GAP_ST && state_d == IDLE) begin
        host_done <= 1'b1;
        host_err  <= err_q;
        if (!cmd_q && !err_q) host_rdata <= rdata_sh_q;
      end
    end
  end

endmodule

// File: tb/tb_twp_master.sv
module tb_twp_master;

  localparam int GAP_P     = 2;
  localparam int TIMEOUT_P = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        host_req = 1'b0;
  logic        host_cmd = 1'b0;
  logic [7:0]  host_addr = 8'h00;
  logic [15:0] host_wdata = 16'h0000;
  logic        host_ready, host_done, host_err, scl;
  logic [15:0] host_rdata;
  wire         sda_bus;
  logic        slv_oe = 1'b0;
  logic        slv_val = 1'b1;

  assign sda_bus = slv_oe ? slv_val : 1'bz;
  pullup (sda_bus);

  twp_master #(.GAP(GAP_P), .TIMEOUT(TIMEOUT_P)) dut (
    .clk(clk), .reset_n(reset_n), .host_req(host_req), .host_cmd(host_cmd),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ready(host_ready),
    .host_done(host_done), .host_rdata(host_rdata), .host_err(host_err),
    .SCL(scl), .SDA(sda_bus)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; bit sda; bit chk_sda; bit oe; bit scl; bit rdy;} bit_exp_t;
  typedef struct {int cyc; bit err; logic [15:0] rdata;} done_exp_t;
  typedef struct {int cyc; bit oe; bit val;} slv_ev_t;

  bit_exp_t  bq[$];
  done_exp_t dq[$];
  slv_ev_t   sq[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [15:0] exp_rdata = 16'h0000;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Slave model: replays queued per-cycle drive events just after each edge.
  always @(posedge clk) begin
    #1;
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      slv_ev_t ev;
      ev = sq.pop_front();
      slv_oe  = ev.oe;
      slv_val = ev.val;
    end
  end

  // Monitor: per-cycle pin expectations and completion scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      while (bq.size() > 0 && bq[0].cyc < cyc) begin
        void'(bq.pop_front());
        check("pin_slot_missed", 32'd1, 32'd0);
      end
      if (bq.size() > 0 && bq[0].cyc == cyc) begin
        bit_exp_t e;
        e = bq.pop_front();
        check("sda_oe", {31'd0, dut.oe_q}, {31'd0, e.oe});
        if (e.chk_sda) check("sda", {31'd0, sda_bus}, {31'd0, e.sda});
        check("scl", {31'd0, scl}, {31'd0, e.scl});
        check("host_ready", {31'd0, host_ready}, {31'd0, e.rdy});
      end
      if (host_done) begin
        if (dq.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          done_exp_t d;
          d = dq.pop_front();
          check("done_cycle", cyc, d.cyc);
          check("host_err", {31'd0, host_err}, {31'd0, d.err});
          check("host_rdata", {16'd0, host_rdata}, {16'd0, d.rdata});
        end
      end
    end
  end

  task automatic push_bit(input int a, input int c, input int last_c, input bit sda,
                          input bit chk, input bit oe, input bit s, input bit rdy);
    bit_exp_t e;
    if (c > last_c) return;
    e.cyc = a + c; e.sda = sda; e.chk_sda = chk; e.oe = oe; e.scl = s; e.rdy = rdy;
    bq.push_back(e);
  endtask

  task automatic push_slv(input int c, input bit oe, input bit val);
    slv_ev_t ev;
    ev.cyc = c; ev.oe = oe; ev.val = val;
    sq.push_back(ev);
  endtask

  // Expected frame for a transaction accepted so that c0 == cycle a.
  task automatic plan(input int a, input bit cmd, input logic [7:0] addr,
                      input logic [15:0] wd, input int delay, input bit respond,
                      input logic [15:0] sdata, input int last_c, input bit push_done);
    int g, rel_end;
    done_exp_t d;
    push_bit(a, 0, last_c, 1'b0, 1, 1, 0, 0);
    push_bit(a, 1, last_c, cmd, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) push_bit(a, 2 + i, last_c, addr[i], 1, 1, 0, 0);
    if (cmd) begin
      for (int i = 0; i < 16; i++) push_bit(a, 10 + i, last_c, wd[i], 1, 1, 0, 0);
      g = 26;
    end else begin
      rel_end = respond ? 30 + delay : 9 + TIMEOUT_P;
      for (int c = 10; c <= rel_end; c++) push_bit(a, c, last_c, 1'b1, 0, 0, 0, 0);
      g = rel_end + 1;
      if (respond) begin
        for (int c = 11; c <= 12 + delay; c++) push_slv(a + c, 1, 1'b1);
        push_slv(a + 13 + delay, 1, 1'b0);
        for (int i = 0; i < 16; i++) push_slv(a + 14 + delay + i, 1, sdata[i]);
        push_slv(a + 30 + delay, 1, 1'b1);
        push_slv(a + 31 + delay, 0, 1'b1);
      end
    end
    for (int c = g; c < g + GAP_P; c++) push_bit(a, c, last_c, 1'b1, 1, 1, 0, 0);
    push_bit(a, g + GAP_P, last_c, 1'b1, 1, 1, 1, 1);
    if (push_done) begin
      if (!cmd && respond) exp_rdata = sdata;
      d.cyc = a + g + GAP_P; d.err = !cmd && !respond; d.rdata = exp_rdata;
      dq.push_back(d);
    end
  endtask

  task automatic issue(input bit cmd, input logic [7:0] addr, input logic [15:0] wd,
                       input int delay, input bit respond, input logic [15:0] sdata,
                       input int last_c, input bit push_done, output int a);
    int n;
    @(negedge clk);
    host_req = 1'b1; host_cmd = cmd; host_addr = addr; host_wdata = wd;
    n = 0;
    while (!host_ready && n < 100) begin @(negedge clk); n++; end
    check("ready_wait_timeout", {31'd0, host_ready}, 32'd1);
    a = cyc + 1;
    plan(a, cmd, addr, wd, delay, respond, sdata, last_c, push_done);
    @(negedge clk);
    host_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((bq.size() > 0 || dq.size() > 0) && n < 300) begin @(negedge clk); n++; end
    check("drain_pins_left", bq.size(), 0);
    check("drain_done_left", dq.size(), 0);
  endtask

  initial begin
    int a, a1, a2;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_sda", {31'd0, sda_bus}, 32'd1);
    check("rst_oe", {31'd0, dut.oe_q}, 32'd1);
    check("rst_scl", {31'd0, scl}, 32'd1);
    check("rst_ready", {31'd0, host_ready}, 32'd1);
    check("rst_done", {31'd0, host_done}, 32'd0);
    check("rst_err", {31'd0, host_err}, 32'd0);
    check("rst_rdata", {16'd0, host_rdata}, 32'h0);

    // Write 0x3C <- 0xA5F0: done at c28.
    issue(1, 8'h3C, 16'hA5F0, 0, 0, 16'h0, 1000, 1, a);
    drain();
    // Read 0x81, nominal slave reply 0x1234: done at c33.
    issue(0, 8'h81, 16'h0, 0, 1, 16'h1234, 1000, 1, a);
    drain();
    // Read with no slave: timeout, done at c20, err=1, rdata kept.
    issue(0, 8'h10, 16'h0, 0, 0, 16'h0, 1000, 1, a);
    drain();
    // Read with the marker 3 cycles late: done at c36.
    issue(0, 8'h55, 16'h0, 3, 1, 16'hBEEF, 1000, 1, a);
    drain();

    // Back-to-back: write then read with host_req held high.
    @(negedge clk);
    host_req = 1'b1; host_cmd = 1'b1; host_addr = 8'h0F; host_wdata = 16'h8001;
    a1 = cyc + 1;
    check("b2b_ready", {31'd0, host_ready}, 32'd1);
    plan(a1, 1, 8'h0F, 16'h8001, 0, 0, 16'h0, 1000, 1);
    @(negedge clk);
    host_cmd = 1'b0; host_addr = 8'h22; host_wdata = 16'h0000;
    a2 = a1 + 29;
    plan(a2, 0, 8'h22, 16'h0, 0, 1, 16'h5A5A, 1000, 1);
    while (cyc < a2) @(negedge clk);
    host_req = 1'b0;
    drain();

    // Reset asserted during c15 of a write.
    issue(1, 8'h3C, 16'hA5F0, 0, 0, 16'h0, 14, 0, a);
    while (cyc < a + 15) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_sda", {31'd0, sda_bus}, 32'd1);
    check("midrst_scl", {31'd0, scl}, 32'd1);
    check("midrst_ready", {31'd0, host_ready}, 32'd1);
    check("midrst_done", {31'd0, host_done}, 32'd0);
    check("midrst_rdata", {16'd0, host_rdata}, 32'h0);
    exp_rdata = 16'h0000;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    issue(1, 8'h5A, 16'h0F0F, 0, 0, 16'h0, 1000, 1, a);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
